adc_sequencer: RTL
==================

ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the modular ADC.
REQ-002 Parameter TIMEOUT, default 1023: cycles allowed in WAIT before an aborted conversion.
REQ-003 clock  in  1  system clock, 50 MHz, all flops rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester conversion request; requester holds it until its req_ready.
REQ-006 req_channel  in  5*NUM_REQ  requested ADC channel; requester i at bits [5i+4:5i].
REQ-007 req_ready  out  NUM_REQ  one-hot, one-cycle pulse: request i accepted.
REQ-008 rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: result for requester i.
REQ-009 rsp_data  out  12  conversion result, valid with rsp_valid.
REQ-010 rsp_timeout  out  1  with rsp_valid: conversion aborted, rsp_data = 0.
REQ-011 cmd_valid / cmd_channel / cmd_sop / cmd_eop  out  1/5/1/1  ADC command stream.
REQ-012 cmd_ready  in  1  ADC command ready.
REQ-013 adc_rsp_valid / adc_rsp_channel / adc_rsp_data  in  1/5/12  ADC response stream.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, CMD, WAIT; exactly one conversion outstanding at any time.
REQ-016 IDLE: if any req_valid, grant round-robin starting at (last_grant+1) mod NUM_REQ; pulse req_ready[g], latch channel and g, go CMD next cycle.
REQ-017 Grant pointer updates only on a grant; with a single requester it is granted every time.
REQ-018 CMD: cmd_valid=1, cmd_sop=cmd_eop=1, cmd_channel=latched channel; all held stable until cmd_ready.
REQ-019 CMD: cycle with cmd_valid && cmd_ready -> WAIT, cmd_valid low next cycle, timer cleared to 0.
REQ-020 WAIT: adc_rsp_valid with adc_rsp_channel == latched channel -> next cycle rsp_valid[g]=1, rsp_data=adc_rsp_data, rsp_timeout=0; go IDLE.
REQ-021 WAIT: adc_rsp_valid with mismatched channel is discarded; timer continues.
REQ-022 WAIT: timer increments each cycle; on timer == TIMEOUT -> rsp_valid[g]=1, rsp_timeout=1, rsp_data=0; go IDLE.
REQ-023 Matching response in the same cycle timer hits TIMEOUT: response wins, rsp_timeout=0.
REQ-024 adc_rsp_valid in IDLE or CMD is ignored.
REQ-025 Latency: grant cycle N -> cmd_valid at N+1; result pulse exactly 1 cycle after matching adc_rsp_valid.
REQ-026 No new grant in the cycle rsp_valid is asserted; next grant earliest the cycle after (back in IDLE).
REQ-027 req_valid dropped by a requester after grant does not cancel the conversion.
REQ-028 Timer width = clog2(TIMEOUT+1); no wrap possible.

Reset
REQ-029 reset asserted: state IDLE, last_grant = NUM_REQ-1 (requester 0 wins first), timer 0.
REQ-030 reset asserted: req_ready, rsp_valid, rsp_timeout, cmd_valid, busy = 0; rsp_data, cmd_channel = 0; cmd_sop/cmd_eop = 0.
REQ-031 reset mid-conversion: conversion abandoned, no rsp_valid emitted; a late ADC response after release is ignored (IDLE).

Structure
REQ-032 Package adc_seq_pkg: state enum, CH_W=5, DATA_W=12, CH_TEMP=5'd17 (die temperature diode).
REQ-033 Sub-module rr_arbiter (NUM_REQ requests, grant enable, one-hot grant, pointer) instantiated once; rest in adc_sequencer.

Verification
REQ-034 Single request: req_valid=0001, ch 17, cmd_ready=1, ADC responds 3 cycles later data 12'hD9A -> rsp_valid=0001, rsp_data=12'hD9A, rsp_timeout=0.
REQ-035 All four requesting continuously -> grant order 0,1,2,3,0; exactly one cmd_valid per conversion.
REQ-036 cmd_ready low 5 cycles -> cmd_valid, cmd_channel stable all 5 cycles, single handshake.
REQ-037 No ADC response, TIMEOUT=15 -> rsp_valid with rsp_timeout=1, rsp_data=0 16 cycles after handshake; busy then low.
REQ-038 Mismatched channel response (ch 3 while waiting ch 17) then ch 17 -> only ch 17 data returned; match on timeout cycle -> rsp_timeout=0.
REQ-039 reset pulsed during WAIT, ADC responds after release -> no rsp_valid, all outputs at reset values, next grant to requester 0.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types and constants for the ADC conversion sequencer
package adc_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT} state_t;
  localparam int CH_W = 5;
  localparam int DATA_W = 12;
  localparam logic [CH_W-1:0] CH_TEMP = 5'd17;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adc_sequencer_rr_arbiter.sv
// rr_arbiter: round-robin arbiter, search starts one past the last granted requester
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_req        : request vector
//   i_en         : grant enable
//   o_grant      : one-hot grant, combinational
//   o_ptr        : index of the last granted requester
module rr_arbiter import adc_seq_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int PW = ptr_w(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_ptr
);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_j;
  logic          w_any;
  always_comb begin
    w_idx = r_ptr;
    w_j = r_ptr;
    w_any = 1'b0;
    o_grant = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_any && i_req[w_j]) begin
        w_any = 1'b1;
        w_idx = w_j;
      end
    end
    o_grant[w_idx] = i_en && w_any;
  end
  // reset points at the last requester so requester 0 wins the first grant
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_ptr <= PW'(NUM_REQ - 1);
    else if (i_en && w_any) r_ptr <= w_idx;
  assign o_ptr = r_ptr;
endmodule

// File: rtl/adc_sequencer.sv
// adc_sequencer: shares one modular ADC among NUM_REQ requesters, one conversion at a time
//   clock, reset                       : clock, asynchronous active-high reset
//   req_valid/req_channel/req_ready    : per-requester request, 5-bit channel each, one-hot accept pulse
//   rsp_valid/rsp_data/rsp_timeout     : one-hot result pulse, 12-bit data, abort flag
//   cmd_valid/cmd_channel/cmd_sop/eop  : ADC command stream, cmd_ready backpressure
//   adc_rsp_valid/channel/data         : ADC response stream
//   busy                               : high whenever a conversion is in flight
module adc_sequencer import adc_seq_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [CH_W*NUM_REQ-1:0] req_channel,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_timeout,
  output logic                    cmd_valid,
  output logic [CH_W-1:0]         cmd_channel,
  output logic                    cmd_sop,
  output logic                    cmd_eop,
  input  logic                    cmd_ready,
  input  logic                    adc_rsp_valid,
  input  logic [CH_W-1:0]         adc_rsp_channel,
  input  logic [DATA_W-1:0]       adc_rsp_data,
  output logic                    busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = ptr_w(NUM_REQ);
  state_t             r_state, w_next;
  logic [CH_W-1:0]    r_ch, w_ch;
  logic [TW-1:0]      r_timer;
  logic [NUM_REQ-1:0] r_rsp_valid, w_grant, w_onehot;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_rsp_timeout, w_en, w_match, w_done;
  logic [PW-1:0]      w_ptr;
  // no grant while the previous result is still being presented
  assign w_en = (r_state == S_IDLE) && !(|r_rsp_valid) && !reset;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk(clock), .i_rst(reset), .i_req(req_valid), .i_en(w_en),
    .o_grant(w_grant), .o_ptr(w_ptr)
  );
  always_comb begin
    w_ch = '0;
    for (int i = 0; i < NUM_REQ; i++) w_ch = w_grant[i] ? req_channel[i*CH_W +: CH_W] : w_ch;
    // the pointer only moves on a grant, so it names the owner of the conversion in flight
    w_onehot = '0;
    w_onehot[w_ptr] = 1'b1;
    w_match = adc_rsp_valid && (adc_rsp_channel == r_ch);
    // the timer reaches TIMEOUT on the cycle it would increment from TIMEOUT-1
    w_done = (r_state == S_WAIT) && (w_match || r_timer == TW'(TIMEOUT - 1));
    w_next = (r_state == S_IDLE) ? (|w_grant ? S_CMD : S_IDLE) :
             (r_state == S_CMD)  ? (cmd_ready ? S_WAIT : S_CMD) :
             (w_done ? S_IDLE : S_WAIT);
    req_ready = w_grant;
    cmd_valid = r_state == S_CMD;
    cmd_sop = cmd_valid;
    cmd_eop = cmd_valid;
    cmd_channel = cmd_valid ? r_ch : '0;
    busy = r_state != S_IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_ch <= '0;
      r_timer <= '0;
      r_rsp_valid <= '0;
      r_rsp_data <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ch <= |w_grant ? w_ch : r_ch;
      r_timer <= (r_state == S_WAIT) ? TW'(r_timer + 1'b1) : '0;
      r_rsp_valid <= w_done ? w_onehot : '0;
      r_rsp_data <= (w_done && w_match) ? adc_rsp_data : '0;
      r_rsp_timeout <= w_done && !w_match;
    end
  assign rsp_valid = r_rsp_valid;
  assign rsp_data = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;
endmodule
